// File: rtl/llc_mesi_ctrl.sv
// Last-level cache controller: set-associative MESI tag/state store with tree pseudo-LRU.
// Serves one L1/snoop command at a time, drives a blocking bus handshake and L1 messages.
module llc_mesi_ctrl #(
    parameter int ADDR_BITS  = 32,
    parameter int SETS       = 16,
    parameter int WAYS       = 8,
    parameter int LINE_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_cmd,
    input  logic [ADDR_BITS-1:0] req_addr,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic [1:0]           resp_snoop,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [1:0]           bus_op,
    output logic [ADDR_BITS-1:0] bus_addr,
    input  logic [1:0]           bus_snoop,
    output logic                 l1_msg_valid,
    output logic [1:0]           l1_msg,
    output logic [ADDR_BITS-1:0] l1_msg_addr,
    output logic [31:0]          reads,
    output logic [31:0]          writes,
    output logic [31:0]          hits,
    output logic [31:0]          misses
);
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_BITS - OFF - IDX;
    localparam int LW  = $clog2(WAYS);
    localparam int PW  = WAYS - 1;

    localparam logic [1:0] SN_HIT = 2'd0, SN_HITM = 2'd1, SN_NOHIT = 2'd2;
    localparam logic [1:0] BUS_READ = 2'd0, BUS_WRITE = 2'd1, BUS_INV = 2'd2, BUS_RWIM = 2'd3;
    localparam logic [1:0] MSG_GET = 2'd0, MSG_SEND = 2'd1, MSG_INV = 2'd2, MSG_EVICT = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, GETL, WB, EVCT, BUSOP, RESP, CLR} fsm_t;
    typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;

    fsm_t                  state, state_d;
    logic [3:0]            cmd_q;
    logic [ADDR_BITS-OFF-1:0] line_q;
    logic [LW-1:0]         way_q;
    logic [TAG-1:0]        vtag_q;
    logic [1:0]            op_q;
    logic                  hit_q, send_q, inv_q, snp_q;
    logic [1:0]            snoop_q;
    mesi_t                 snp_next_q;

    mesi_t                 st_q   [SETS][WAYS];
    logic [TAG-1:0]        tag_q  [SETS][WAYS];
    logic [PW-1:0]         plru_q [SETS];

    logic [IDX-1:0]        set_idx;
    logic [TAG-1:0]        req_tag;
    logic                  hit, inv_found, is_rd, is_wr, is_snp;
    logic [LW-1:0]         hit_way, inv_way, victim;
    mesi_t                 hit_st, vic_st;
    logic [ADDR_BITS-1:0]  line_addr, vic_addr;
    logic                  unused;

    // Path bits from the root spell the victim way index, MSB first.
    function automatic logic [LW-1:0] plru_victim(input logic [PW-1:0] t);
        logic [PW-1:0] sh;
        logic [LW-1:0] v;
        int n;
        v = '0;
        n = 0;
        for (int l = 0; l < LW; l++) begin
            sh = t >> n;
            v  = (v << 1) | LW'(sh[0]);
            n  = 2 * n + 1 + (sh[0] ? 1 : 0);
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [LW-1:0] w);
        logic [PW-1:0] r, mask;
        logic [LW-1:0] sh;
        int n;
        r = t;
        n = 0;
        for (int l = 0; l < LW; l++) begin
            sh   = w >> (LW - 1 - l);
            mask = PW'(1) << n;
            r    = sh[0] ? (r & ~mask) : (r | mask);
            n    = 2 * n + 1 + (sh[0] ? 1 : 0);
        end
        return r;
    endfunction

    assign unused    = ^req_addr[OFF-1:0];
    assign set_idx   = line_q[IDX-1:0];
    assign req_tag   = line_q[ADDR_BITS-OFF-1:IDX];
    assign line_addr = {line_q, {OFF{1'b0}}};
    assign vic_addr  = {vtag_q, set_idx, {OFF{1'b0}}};
    assign is_rd     = (cmd_q == 4'd0) || (cmd_q == 4'd2);
    assign is_wr     = (cmd_q == 4'd1);
    assign is_snp    = (cmd_q >= 4'd3) && (cmd_q <= 4'd6);

    // Descending scan so the lowest-index way wins for both hit and free-way search.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (st_q[set_idx][w] == ST_I) begin
                inv_found = 1'b1;
                inv_way   = LW'(w);
            end else if (tag_q[set_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = LW'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim(plru_q[set_idx]);
        hit_st = st_q[set_idx][hit_way];
        vic_st = st_q[set_idx][victim];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (req_valid) state_d = (req_cmd == 4'd8) ? CLR : LOOKUP;
            LOOKUP: begin
                if (is_rd || is_wr) begin
                    if (hit)                  state_d = (is_wr && hit_st == ST_S) ? BUSOP : RESP;
                    else if (vic_st == ST_M)  state_d = GETL;
                    else if (vic_st != ST_I)  state_d = EVCT;
                    else                      state_d = BUSOP;
                end else if ((cmd_q == 4'd4 || cmd_q == 4'd6) && hit && hit_st == ST_M) begin
                    state_d = GETL;
                end else begin
                    state_d = RESP;
                end
            end
            GETL:   state_d = WB;
            WB:     if (bus_ready) state_d = snp_q ? RESP : EVCT;
            EVCT:   state_d = BUSOP;
            BUSOP:  if (bus_ready) state_d = RESP;
            RESP:   state_d = IDLE;
            CLR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) st_q[s][w] <= ST_I;
            end
            cmd_q <= '0; line_q <= '0; way_q <= '0; vtag_q <= '0; op_q <= BUS_READ;
            hit_q <= 1'b0; send_q <= 1'b0; inv_q <= 1'b0; snp_q <= 1'b0;
            snoop_q <= SN_NOHIT; snp_next_q <= ST_I;
            reads <= '0; writes <= '0; hits <= '0; misses <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cmd_q   <= req_cmd;
                    line_q  <= req_addr[ADDR_BITS-1:OFF];
                    hit_q   <= 1'b0;
                    send_q  <= 1'b0;
                    inv_q   <= 1'b0;
                    snoop_q <= SN_NOHIT;
                end
                LOOKUP: begin
                    hit_q <= hit;
                    snp_q <= is_snp;
                    if (is_rd) reads  <= reads + 32'd1;
                    if (is_wr) writes <= writes + 32'd1;
                    if (is_rd || is_wr) begin
                        if (hit) begin
                            hits <= hits + 32'd1;
                            plru_q[set_idx] <= plru_touch(plru_q[set_idx], hit_way);
                            way_q <= hit_way;
                            op_q  <= BUS_INV;
                            if (is_rd)                send_q <= 1'b1;
                            else if (hit_st != ST_S)  st_q[set_idx][hit_way] <= ST_M;
                        end else begin
                            misses <= misses + 32'd1;
                            way_q  <= victim;
                            vtag_q <= tag_q[set_idx][victim];
                            op_q   <= is_rd ? BUS_READ : BUS_RWIM;
                            send_q <= is_rd;
                        end
                    end else if (hit) begin
                        way_q  <= hit_way;
                        vtag_q <= req_tag;
                        case (cmd_q)
                            4'd3: if (hit_st == ST_S) begin
                                st_q[set_idx][hit_way] <= ST_I;
                                snoop_q <= SN_HIT;
                                inv_q   <= 1'b1;
                            end
                            4'd4: begin
                                snoop_q <= (hit_st == ST_M) ? SN_HITM : SN_HIT;
                                if (hit_st == ST_M) snp_next_q <= ST_S;
                                else                st_q[set_idx][hit_way] <= ST_S;
                            end
                            4'd6: begin
                                snoop_q <= (hit_st == ST_M) ? SN_HITM : SN_HIT;
                                inv_q   <= 1'b1;
                                if (hit_st == ST_M) snp_next_q <= ST_I;
                                else                st_q[set_idx][hit_way] <= ST_I;
                            end
                            default: ;
                        endcase
                    end
                end
                // Dirty snooped line changes state only once its data is on the bus.
                WB: if (bus_ready && snp_q) st_q[set_idx][way_q] <= snp_next_q;
                EVCT: st_q[set_idx][way_q] <= ST_I;
                BUSOP: if (bus_ready) begin
                    case (op_q)
                        BUS_READ: begin
                            st_q[set_idx][way_q] <= (bus_snoop == SN_HIT || bus_snoop == SN_HITM) ? ST_S : ST_E;
                            plru_q[set_idx] <= plru_touch(plru_q[set_idx], way_q);
                        end
                        BUS_RWIM: begin
                            st_q[set_idx][way_q] <= ST_M;
                            plru_q[set_idx] <= plru_touch(plru_q[set_idx], way_q);
                        end
                        default: st_q[set_idx][way_q] <= ST_M;
                    endcase
                end
                CLR: for (int s = 0; s < SETS; s++) begin
                    plru_q[s] <= '0;
                    for (int w = 0; w < WAYS; w++) st_q[s][w] <= ST_I;
                end
                default: ;
            endcase
        end
    end

    // Tags survive reset and clear; only the MESI state says whether they mean anything.
    always_ff @(posedge clk) begin
        if (state == BUSOP && bus_ready && op_q != BUS_INV) tag_q[set_idx][way_q] <= req_tag;
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_hit   = hit_q;
    assign resp_snoop = snoop_q;
    assign bus_valid  = (state == WB) || (state == BUSOP);
    assign bus_op     = (state == WB) ? BUS_WRITE : op_q;
    assign bus_addr   = (state == WB) ? vic_addr : line_addr;

    always_comb begin
        l1_msg_valid = 1'b0;
        l1_msg       = MSG_GET;
        l1_msg_addr  = vic_addr;
        case (state)
            GETL: l1_msg_valid = 1'b1;
            EVCT: begin
                l1_msg_valid = 1'b1;
                l1_msg       = MSG_EVICT;
            end
            RESP: begin
                l1_msg_valid = send_q | inv_q;
                l1_msg       = send_q ? MSG_SEND : MSG_INV;
                l1_msg_addr  = line_addr;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_llc_mesi_ctrl.sv
// Scoreboard bench for llc_mesi_ctrl: directed commands push expected responses,
// bus operations and L1 messages; negedge monitors pop and compare them.
module tb_llc_mesi_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_cmd = '0;
    logic [31:0] req_addr = '0;
    logic        resp_valid, resp_hit;
    logic [1:0]  resp_snoop;
    logic        bus_valid, bus_ready = 1'b1;
    logic [1:0]  bus_op, bus_snoop = 2'd2;
    logic [31:0] bus_addr;
    logic        l1_msg_valid;
    logic [1:0]  l1_msg;
    logic [31:0] l1_msg_addr, reads, writes, hits, misses;

    typedef struct { logic hit; logic [1:0] snp; logic chk; } resp_t;
    typedef struct { logic [1:0] op; logic [31:0] addr; } xfer_t;
    resp_t resp_q[$];
    xfer_t bus_q[$];
    xfer_t msg_q[$];
    resp_t re;
    xfer_t be, me;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    llc_mesi_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_snoop(resp_snoop), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_op(bus_op),
        .bus_addr(bus_addr), .bus_snoop(bus_snoop), .l1_msg_valid(l1_msg_valid), .l1_msg(l1_msg),
        .l1_msg_addr(l1_msg_addr), .reads(reads), .writes(writes), .hits(hits), .misses(misses)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] a);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected event, addr %h", nm, a);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                if (resp_q.size() == 0) unexpected("resp", 32'h0);
                else begin
                    re = resp_q.pop_front();
                    check("resp_hit", resp_hit, re.hit);
                    if (re.chk) check("resp_snoop", resp_snoop, re.snp);
                end
            end
            if (bus_valid && bus_ready) begin
                if (bus_q.size() == 0) unexpected("bus", bus_addr);
                else begin
                    be = bus_q.pop_front();
                    check("bus_op", bus_op, be.op);
                    check("bus_addr", bus_addr, be.addr);
                end
            end
            if (l1_msg_valid) begin
                if (msg_q.size() == 0) unexpected("l1_msg", l1_msg_addr);
                else begin
                    me = msg_q.pop_front();
                    check("l1_msg", l1_msg, me.op);
                    check("l1_msg_addr", l1_msg_addr, me.addr);
                end
            end
        end
    end

    task automatic exp_resp(input logic h, input logic [1:0] s, input logic c);
        resp_t r;
        r.hit = h; r.snp = s; r.chk = c;
        resp_q.push_back(r);
    endtask

    task automatic exp_bus(input logic [1:0] op, input logic [31:0] a);
        xfer_t x;
        x.op = op; x.addr = a;
        bus_q.push_back(x);
    endtask

    task automatic exp_msg(input logic [1:0] m, input logic [31:0] a);
        xfer_t x;
        x.op = m; x.addr = a;
        msg_q.push_back(x);
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(nm, req_ready, 1'b1);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [1:0] sn);
        wait_ready("ready_before_cmd");
        bus_snoop = sn; req_cmd = c; req_addr = a; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_ready("ready_after_cmd");
    endtask

    task automatic cnt(input int r, input int w, input int h, input int m);
        check("reads", reads, r);
        check("writes", writes, w);
        check("hits", hits, h);
        check("misses", misses, m);
    endtask

    task automatic drain();
        repeat (2) @(negedge clk);
        check("resp_q_left", resp_q.size(), 0);
        check("bus_q_left", bus_q.size(), 0);
        check("msg_q_left", msg_q.size(), 0);
    endtask

    task automatic reset_checks();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_l1_valid", l1_msg_valid, 1'b0);
        check("rst_resp_hit", resp_hit, 1'b0);
        check("rst_resp_snoop", resp_snoop, 2'd2);
        cnt(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Read-miss fill (NOHIT -> E) returns: resp miss, bus READ, SENDLINE.
    task automatic read_miss(input logic [31:0] a, input logic [1:0] sn);
        exp_resp(1'b0, 2'd2, 1'b0);
        exp_bus(2'd0, a);
        exp_msg(2'd1, a);
        issue(4'd0, a, sn);
    endtask

    task automatic read_hit(input logic [31:0] a, input logic [31:0] line);
        exp_resp(1'b1, 2'd2, 1'b0);
        exp_msg(2'd1, line);
        issue(4'd0, a, 2'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 reset_checks();
        rst_n = 1'b1;

        // Fill, hit, then fill all 8 ways of set 0 and force a PLRU eviction.
        read_miss(32'h400, 2'd2);
        cnt(1, 0, 0, 1);
        read_hit(32'h405, 32'h400);
        cnt(2, 0, 1, 1);
        for (int k = 2; k <= 8; k++) read_miss(32'h400 * k, 2'd2);
        exp_msg(2'd3, 32'h400);
        read_miss(32'h2400, 2'd2);
        read_hit(32'h800, 32'h800);
        cnt(11, 0, 2, 9);
        drain();

        // Shared line upgraded by a write, then snooped while Modified.
        do_reset();
        read_miss(32'h800, 2'd0);
        exp_resp(1'b1, 2'd2, 1'b0);
        exp_bus(2'd2, 32'h800);
        issue(4'd1, 32'h800, 2'd2);
        exp_resp(1'b1, 2'd1, 1'b1);
        exp_msg(2'd0, 32'h800);
        exp_bus(2'd1, 32'h800);
        issue(4'd4, 32'h800, 2'd2);
        cnt(1, 1, 1, 1);
        drain();

        // Snoop sequences on a Modified line and a Shared line.
        do_reset();
        exp_resp(1'b0, 2'd2, 1'b0);
        exp_bus(2'd3, 32'hC00);
        issue(4'd1, 32'hC00, 2'd2);
        exp_resp(1'b1, 2'd1, 1'b1);
        exp_msg(2'd0, 32'hC00);
        exp_bus(2'd1, 32'hC00);
        issue(4'd4, 32'hC00, 2'd2);
        exp_resp(1'b1, 2'd0, 1'b1);
        exp_msg(2'd2, 32'hC00);
        issue(4'd6, 32'hC00, 2'd2);
        exp_resp(1'b0, 2'd2, 1'b1);
        issue(4'd4, 32'hC00, 2'd2);
        exp_resp(1'b0, 2'd2, 1'b1);
        issue(4'd5, 32'hC00, 2'd2);
        read_miss(32'h1000, 2'd1);
        exp_resp(1'b1, 2'd0, 1'b1);
        exp_msg(2'd2, 32'h1000);
        issue(4'd3, 32'h1000, 2'd2);
        read_miss(32'h1000, 2'd2);
        cnt(2, 1, 0, 3);
        drain();

        // Stalled bus fill, busy-time request ignored, reset mid-transaction.
        do_reset();
        bus_ready = 1'b0;
        wait_ready("stall_ready");
        req_cmd = 4'd0; req_addr = 32'h400; req_valid = 1'b1;
        @(posedge clk);
        #1 req_cmd = 4'd1; req_addr = 32'h1440;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_bus_valid", bus_valid, 1'b1);
            check("stall_bus_op", bus_op, 2'd0);
            check("stall_bus_addr", bus_addr, 32'h400);
            check("stall_req_ready", req_ready, 1'b0);
        end
        #2 rst_n = 1'b0;
        #1 check("async_bus_valid", bus_valid, 1'b0);
        req_valid = 1'b0;
        reset_checks();
        bus_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        read_miss(32'h400, 2'd2);
        cnt(1, 0, 0, 1);

        // Clear drops every line but keeps the counters.
        read_miss(32'h800, 2'd2);
        read_hit(32'h400, 32'h400);
        cnt(3, 0, 1, 2);
        issue(4'd8, 32'h0, 2'd2);
        cnt(3, 0, 1, 2);
        read_miss(32'h400, 2'd2);
        read_miss(32'h800, 2'd2);
        cnt(5, 0, 1, 4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
